// File: rtl/uart_pkg.sv
// Shared encodings for the UART core: parity modes and the TX/RX state machines.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Mode 2'b11 carries no parity bit, same as PARITY_NONE.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous count-based FIFO; head data comes straight from the storage registers.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Occupancy only moves when exactly one of push/pop is accepted.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: shared oversample tick, TX/RX framing FSMs, FIFO on each direction.
module uart_core
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic [WIDTH-1:0]     tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overflow
);

  localparam int OVS_CW = $clog2(2 * OVERSAMPLE);
  localparam int BIT_CW = $clog2(WIDTH);

  // ---------------------------------------------------------------- tick
  logic [DIV_WIDTH-1:0] tick_cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 tick;

  assign tick = (tick_cnt_q == div_q);

  // Oversample tick; a new divisor is only picked up at wrap so periods never tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      div_q      <= baud_div;
    end else if (tick) begin
      tick_cnt_q <= '0;
      div_q      <= baud_div;
    end else begin
      tick_cnt_q <= tick_cnt_q + DIV_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------- TX
  logic             tx_full;
  logic             tx_empty;
  logic             tx_pop;
  logic [WIDTH-1:0] tx_head;

  assign tx_ready = !tx_full;

  uart_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .full_o  (tx_full),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .empty_o (tx_empty)
  );

  tx_state_e         tx_state_q;
  logic [OVS_CW-1:0] tx_ovs_q;
  logic [BIT_CW-1:0] tx_bit_q;
  logic [BIT_CW-1:0] tx_bit_d;
  logic [WIDTH-1:0]  tx_word_q;
  logic [1:0]        tx_mode_q;
  logic              tx_two_q;
  logic              tx_q;
  logic              tx_busy_q;
  logic              tx_bit_end;
  logic              tx_stop_end;

  assign tx_pop      = (tx_state_q == TX_IDLE) && tick && !tx_empty;
  assign tx_bit_d    = tx_bit_q + BIT_CW'(1);
  assign tx_bit_end  = tick && (tx_ovs_q == OVS_CW'(OVERSAMPLE - 1));
  assign tx_stop_end = tick && (tx_ovs_q == (tx_two_q ? OVS_CW'(2 * OVERSAMPLE - 1)
                                                      : OVS_CW'(OVERSAMPLE - 1)));
  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  // Transmit framer: the line level is registered and changes only on state boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_ovs_q   <= '0;
      tx_bit_q   <= '0;
      tx_word_q  <= '0;
      tx_mode_q  <= PARITY_NONE;
      tx_two_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      if (tick && (tx_state_q != TX_IDLE)) begin
        tx_ovs_q <= tx_ovs_q + OVS_CW'(1);
      end
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_word_q  <= tx_head;
            tx_mode_q  <= parity_mode;
            tx_two_q   <= two_stop;
            tx_ovs_q   <= '0;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_ovs_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_word_q[0];
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_ovs_q <= '0;
            if (tx_bit_q == BIT_CW'(WIDTH - 1)) begin
              if (parity_on(tx_mode_q)) begin
                tx_q       <= (^tx_word_q) ^ (tx_mode_q == PARITY_ODD);
                tx_state_q <= TX_PARITY;
              end else begin
                tx_q       <= 1'b1;
                tx_state_q <= TX_STOP;
              end
            end else begin
              tx_bit_q <= tx_bit_d;
              tx_q     <= tx_word_q[tx_bit_d];
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_ovs_q   <= '0;
            tx_q       <= 1'b1;
            tx_state_q <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_stop_end) begin
            tx_ovs_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e         rx_state_q;
  logic [OVS_CW-1:0] rx_ovs_q;
  logic [BIT_CW-1:0] rx_bit_q;
  logic [WIDTH-1:0]  rx_shift_q;
  logic [1:0]        rx_mode_q;
  logic              rx_par_q;
  logic              overflow_q;
  logic              rx_half;
  logic              rx_bit_end;
  logic              rx_push;
  logic              rx_par_err;
  logic              rx_full;
  logic              rx_empty;
  logic [WIDTH+1:0]  rx_entry;
  logic [WIDTH+1:0]  rx_head;

  assign rx_half    = tick && (rx_ovs_q == OVS_CW'(OVERSAMPLE / 2 - 1));
  assign rx_bit_end = tick && (rx_ovs_q == OVS_CW'(OVERSAMPLE - 1));
  assign rx_push    = (rx_state_q == RX_STOP) && rx_bit_end;
  assign rx_par_err = parity_on(rx_mode_q) &&
                      (rx_par_q != ((^rx_shift_q) ^ (rx_mode_q == PARITY_ODD)));
  assign rx_entry   = {!rx_sync_q, rx_par_err, rx_shift_q};

  uart_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .wdata_i (rx_entry),
    .full_o  (rx_full),
    .pop_i   (rx_ready),
    .rdata_o (rx_head),
    .empty_o (rx_empty)
  );

  assign rx_valid     = !rx_empty;
  assign rx_data      = rx_head[WIDTH-1:0];
  assign parity_error = rx_head[WIDTH];
  assign frame_error  = rx_head[WIDTH+1];
  assign overflow     = overflow_q;

  // Receive framer: start is validated at half a bit, every later bit sampled at its centre.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_ovs_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_mode_q  <= PARITY_NONE;
      rx_par_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= rx_push && rx_full;
      if (tick) begin
        rx_ovs_q <= rx_ovs_q + OVS_CW'(1);
      end
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_ovs_q   <= '0;
            rx_mode_q  <= parity_mode;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_half) begin
            rx_ovs_q <= '0;
            rx_bit_q <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_ovs_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[WIDTH-1:1]};
            if (rx_bit_q == BIT_CW'(WIDTH - 1)) begin
              rx_state_q <= parity_on(rx_mode_q) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + BIT_CW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (rx_bit_end) begin
            rx_ovs_q   <= '0;
            rx_par_q   <= rx_sync_q;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_ovs_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: vector table plus scoreboard of received words.
module tb_uart_core;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int OVS     = 16;
  localparam int DIVW    = 16;
  localparam int BAUD    = 3;
  localparam int BIT_CLK = (BAUD + 1) * OVS;

  logic            clk;
  logic            rst;
  logic [DIVW-1:0] baud_div;
  logic [1:0]      parity_mode;
  logic            two_stop;
  logic [WIDTH-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            tx;
  logic            tx_busy;
  logic            rx;
  logic [WIDTH-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            parity_error;
  logic            frame_error;
  logic            overflow;

  logic loopEn;
  logic rxDrv;

  assign rx = loopEn ? tx : rxDrv;

  uart_core #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH),
    .OVERSAMPLE (OVS),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_div     (baud_div),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         isLoop;
    logic [7:0] data;
    logic [1:0] pmode;
    logic       twoStop;
    logic       flipPar;
    logic       badStop;
    int         expBusy;
    logic [7:0] expData;
    logic       expPerr;
    logic       expFerr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rxExp_t;

  vec_t   vecs[10];
  rxExp_t sbq[$];
  rxExp_t monExp;
  int     vectors = 0;
  int     miscompares = 0;
  int     ovfCount = 0;
  int     ovfBase;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectRx(input logic [7:0] d, input logic perr, input logic ferr);
    rxExp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    sbq.push_back(e);
  endtask

  task automatic waitQueueEmpty(input string name, input int maxCycles);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < maxCycles) begin
      waitCycles(1);
      n++;
    end
    checkOutput(name, sbq.size(), 0);
  endtask

  task automatic pushTx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    waitCycles(1);
    tx_valid = 1'b0;
  endtask

  // Bit-bangs one frame on rx with the bench's own parity computation.
  task automatic driveFrame(input logic [7:0] d, input logic [1:0] pm,
                            input logic flip, input logic badStop);
    logic p;
    rxDrv = 1'b0;
    waitCycles(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxDrv = d[i];
      waitCycles(BIT_CLK);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      p = ^d;
      if (pm == 2'b10) p = ~p;
      if (flip) p = ~p;
      rxDrv = p;
      waitCycles(BIT_CLK);
    end
    rxDrv = !badStop;
    waitCycles(BIT_CLK);
    if (badStop) begin
      waitCycles(BIT_CLK);
      rxDrv = 1'b1;
    end
    waitCycles(2 * BIT_CLK);
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    int busyLen;
    parity_mode = v.pmode;
    two_stop    = v.twoStop;
    expectRx(v.expData, v.expPerr, v.expFerr);
    if (v.isLoop) begin
      loopEn = 1'b1;
      checkOutput("tx_ready idle", tx_ready, 1);
      pushTx(v.data);
      n = 0;
      while (!tx_busy && n < 100) begin
        waitCycles(1);
        n++;
      end
      busyLen = 0;
      while (tx_busy && busyLen < 2000) begin
        waitCycles(1);
        busyLen++;
      end
      checkOutput("tx frame length", busyLen, v.expBusy);
    end else begin
      loopEn = 1'b0;
      driveFrame(v.data, v.pmode, v.flipPar, v.badStop);
    end
    waitQueueEmpty("rx word arrival", 4 * BIT_CLK);
  endtask

  initial begin
    rst         = 1'b1;
    baud_div    = DIVW'(BAUD);
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    rx_ready    = 1'b1;
    rxDrv       = 1'b1;
    loopEn      = 1'b0;

    //          loop  data   pmode  two   flip  bad   busy  expData perr  ferr
    vecs[0] = '{1'b1, 8'hA5, 2'b01, 1'b0, 1'b0, 1'b0, 704, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h3C, 2'b10, 1'b1, 1'b0, 1'b0, 768, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 640, 8'h5A, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 2'b11, 1'b1, 1'b0, 1'b0, 704, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h3C, 2'b10, 1'b0, 1'b1, 1'b0, 0,   8'h3C, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h3C, 2'b10, 1'b0, 1'b0, 1'b0, 0,   8'h3C, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 0,   8'h55, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h81, 2'b01, 1'b0, 1'b0, 1'b0, 0,   8'h81, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 704, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 8'hC3, 2'b00, 1'b0, 1'b0, 1'b0, 0,   8'hC3, 1'b0, 1'b0};

    fork
      forever begin
        @(negedge clk);
        if (overflow) ovfCount++;
        if (!rst && rx_valid && rx_ready) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected rx word: got 0x%0h, expected none", rx_data);
          end else begin
            monExp = sbq.pop_front();
            checkOutput("rx_data", rx_data, monExp.data);
            checkOutput("parity_error", parity_error, monExp.perr);
            checkOutput("frame_error", frame_error, monExp.ferr);
          end
        end
      end
    join_none

    waitCycles(3);
    checkOutput("reset tx", tx, 1);
    checkOutput("reset tx_busy", tx_busy, 0);
    checkOutput("reset tx_ready", tx_ready, 1);
    checkOutput("reset rx_valid", rx_valid, 0);
    checkOutput("reset rx_data", rx_data, 0);
    checkOutput("reset parity_error", parity_error, 0);
    checkOutput("reset frame_error", frame_error, 0);
    checkOutput("reset overflow", overflow, 0);
    rst = 1'b0;
    waitCycles(2);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] idle glitch");
    loopEn      = 1'b0;
    parity_mode = 2'b00;
    rxDrv       = 1'b0;
    waitCycles(BIT_CLK / 4);
    rxDrv = 1'b1;
    waitCycles(3 * BIT_CLK);
    checkOutput("rx_valid after glitch", rx_valid, 0);
    applyStimulus(vecs[9]);

    $display("[TB] rx overflow");
    rx_ready = 1'b0;
    ovfBase  = ovfCount;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) expectRx(8'(8'h10 + i), 1'b0, 1'b0);
      driveFrame(8'(8'h10 + i), 2'b00, 1'b0, 1'b0);
    end
    checkOutput("overflow pulses", ovfCount - ovfBase, 1);
    checkOutput("rx_valid when full", rx_valid, 1);
    checkOutput("oldest rx_data", rx_data, 8'h10);
    rx_ready = 1'b1;
    waitQueueEmpty("rx drain", 4 * DEPTH);

    $display("[TB] tx fifo fill and reset");
    baud_div = 16'hFFFF;
    waitCycles(10);
    for (int i = 0; i < DEPTH; i++) begin
      pushTx(8'(i));
    end
    checkOutput("tx_ready when full", tx_ready, 0);
    checkOutput("tx_busy while filled", tx_busy, 0);
    baud_div = DIVW'(BAUD);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("tx_ready after reset", tx_ready, 1);

    for (int i = 0; i <= DEPTH; i++) begin
      pushTx(8'(8'hF0 ^ i));
    end
    waitCycles(10);
    checkOutput("tx_ready full mid-frame", tx_ready, 0);
    checkOutput("tx_busy mid-frame", tx_busy, 1);
    checkOutput("tx start bit", tx, 0);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("tx after mid-frame reset", tx, 1);
    checkOutput("tx_ready after mid-frame reset", tx_ready, 1);
    checkOutput("tx_busy after mid-frame reset", tx_busy, 0);
    rst = 1'b0;
    waitCycles(2 * BIT_CLK);
    checkOutput("tx stays idle", tx, 1);
    checkOutput("tx_busy stays idle", tx_busy, 0);

    waitCycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
